// File: rtl/frame_stream_out_if.sv
// Pixel stream bus between the frame readout and its sink.
// Carries valid/ready handshake, pixel data and frame/line markers.
interface frame_stream_out_if #(
  parameter int unsigned PIX_W = 24
);
  logic             iREADY;
  logic             oDVAL;
  logic [PIX_W-1:0] oDATA;
  logic             oSOF;
  logic             oEOL;
  logic             oEOF;

  modport master (
    input  iREADY,
    output oDVAL, oDATA, oSOF, oEOL, oEOF
  );

  modport slave (
    output iREADY,
    input  oDVAL, oDATA, oSOF, oEOL, oEOF
  );
endinterface

// File: rtl/frame_stream_out.sv
// Frame readout: raster-order reads from a pipelined RAM, streamed with credit-based backpressure.
// Define GRAY_OUT_EN to emit 8-bit luma (R+2G+B)>>2 instead of the raw RGB888 word.
module frame_stream_out #(
  parameter int unsigned IMG_W  = 300,
  parameter int unsigned IMG_H  = 210,
  parameter int unsigned PIX_W  = 24,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  input  logic                ena,
  output logic                done,
  frame_stream_out_if.master  vid,
  input  logic [PIX_W-1:0]    oDataA,
  output logic [ADDR_W-1:0]   iAddrA,
  output logic                rdenA,
  output logic                wrenA
);

  localparam int unsigned DEPTH = RD_LAT + 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned X_W   = $clog2(IMG_W);
  localparam int unsigned Y_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [ADDR_W:0] LAST_PIX = (ADDR_W+1)'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT              state;
  logic [ADDR_W:0]    issueCnt;
  logic [RD_LAT-1:0]  pipe;
  logic [PIX_W-1:0]   buffer [DEPTH];
  logic [PTR_W-1:0]   rdPtr;
  logic [PTR_W-1:0]   wrPtr;
  logic [CNT_W-1:0]   bufCount;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;

  logic               dval;
  logic               fire;
  logic               bufWr;
  logic               xLast;
  logic               yLast;
  logic [CNT_W:0]     credit;
  logic [PIX_W-1:0]   head;

  function automatic logic [CNT_W-1:0] countOnes(input logic [RD_LAT-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(RD_LAT); i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit uses registered occupancy only, so a pop frees its slot one cycle later
  assign credit = {1'b0, bufCount} + (CNT_W+1)'(countOnes(pipe));
  assign rdenA  = (state == RUN) && (issueCnt <= LAST_PIX) && (credit < (CNT_W+1)'(DEPTH));
  assign iAddrA = issueCnt[ADDR_W-1:0];
  assign wrenA  = 1'b0;

  assign bufWr = pipe[RD_LAT-1];
  assign dval  = (bufCount != '0);
  assign fire  = dval && vid.iREADY;
  assign xLast = (x == X_W'(IMG_W - 1));
  assign yLast = (y == Y_W'(IMG_H - 1));
  assign head  = buffer[rdPtr];

  assign vid.oDVAL = dval;
  assign vid.oSOF  = dval && (x == '0) && (y == '0);
  assign vid.oEOL  = dval && xLast;
  assign vid.oEOF  = dval && xLast && yLast;

`ifdef GRAY_OUT_EN
  logic [9:0] graySum;
  assign graySum   = 10'(head[23:16]) + {1'b0, head[15:8], 1'b0} + 10'(head[7:0]);
  assign vid.oDATA = {(PIX_W-8)'(0), graySum[9:2]};
`else
  assign vid.oDATA = head;
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= IDLE;
      issueCnt <= '0;
      pipe     <= '0;
      rdPtr    <= '0;
      wrPtr    <= '0;
      bufCount <= '0;
      x        <= '0;
      y        <= '0;
      done     <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) buffer[i] <= '0;
    end else begin
      done <= 1'b0;
      pipe <= RD_LAT'({pipe, rdenA});
      if (rdenA) issueCnt <= issueCnt + (ADDR_W+1)'(1);

      if (bufWr) begin
        buffer[wrPtr] <= oDataA;
        wrPtr         <= ptrInc(wrPtr);
      end
      if (fire) rdPtr <= ptrInc(rdPtr);
      bufCount <= bufCount + CNT_W'(bufWr) - CNT_W'(fire);

      // Raster position of the pixel currently at the buffer head
      if (fire) begin
        if (xLast) begin
          x <= '0;
          y <= yLast ? '0 : y + Y_W'(1);
        end else begin
          x <= x + X_W'(1);
        end
      end

      case (state)
        IDLE: if (ena) state <= RUN;
        RUN: begin
          if (fire && xLast && yLast) begin
            state    <= DONE;
            done     <= 1'b1;
            issueCnt <= '0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
